// File: rtl/dma_block_engine.sv
// dma_block_engine: moves one BLOCK_W block between memory and the accelerator in BUS_W beats.
// Define DMA_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES cycles without mem_ready.
module dma_block_engine #(
    parameter int BLOCK_W        = 1024,
    parameter int BUS_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dma_rx_start,
    input  logic               dma_tx_start,
    input  logic [31:0]        dma_rx_address,
    input  logic [31:0]        dma_tx_address,
    input  logic [BLOCK_W-1:0] dma_tx_data,
    output logic [BLOCK_W-1:0] dma_rx_data,
    output logic               dma_done,
    output logic               dma_idle,
    output logic               dma_error,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [BUS_W-1:0]   mem_wdata,
    input  logic [BUS_W-1:0]   mem_rdata,
    input  logic               mem_ready
);
    localparam int BEATS = BLOCK_W / BUS_W;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      beat_q, beat_d;
    logic [31:0]        addr_q, addr_d;
    logic [BLOCK_W-1:0] tx_q, tx_d, rx_q, rx_d;
    logic               err_q, err_d, dual_q, dual_d;
    logic               busy, last, tmo;

    assign busy = state_q == RD || state_q == WR;
    assign last = beat_q == CW'(BEATS - 1);

`ifdef DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_q;
    assign tmo = busy && !mem_ready && wait_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) wait_q <= '0;
        else       wait_q <= (busy && !mem_ready) ? wait_q + 1'b1 : '0;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        err_d   = err_q;
        dual_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_rx_start && dma_tx_start) begin
                    err_d  = 1'b1;
                    dual_d = 1'b1;
                end else if (dma_rx_start || dma_tx_start) begin
                    addr_d  = dma_rx_start ? dma_rx_address : dma_tx_address;
                    beat_d  = '0;
                    tx_d    = dma_tx_start ? dma_tx_data : tx_q;
                    err_d   = addr_d[1:0] != 2'b00;
                    state_d = err_d ? DONE : (dma_rx_start ? RD : WR);
                end
            end
            RD, WR: begin
                if (mem_ready) begin
                    if (state_q == RD) rx_d[BUS_W*int'(beat_q) +: BUS_W] = mem_rdata;
                    beat_d  = beat_q + 1'b1;
                    addr_d  = addr_q + 32'(BUS_W / 8);
                    tx_d    = tx_q >> BUS_W;
                    state_d = last ? DONE : state_q;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            dual_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            dual_q  <= dual_d;
        end
    end

    // The write word always sits in the low slice because tx_q shifts down per beat.
    assign dma_rx_data = rx_q;
    assign dma_done    = state_q == DONE || dual_q;
    assign dma_idle    = state_q == IDLE;
    assign dma_error   = err_q;
    assign mem_req     = busy;
    assign mem_we      = state_q == WR;
    assign mem_addr    = busy ? addr_q : '0;
    assign mem_wdata   = state_q == WR ? tx_q[BUS_W-1:0] : '0;
endmodule

// File: tb/tb_dma_block_engine.sv
// tb_dma_block_engine: randomized self-checking bench with a word-array memory model.
module tb_dma_block_engine;
    localparam int BLOCK_W = 1024;
    localparam int BUS_W   = 32;
    localparam int BEATS   = BLOCK_W / BUS_W;

    logic               clk = 0, reset = 1;
    logic               dma_rx_start = 0, dma_tx_start = 0;
    logic [31:0]        dma_rx_address = 0, dma_tx_address = 0;
    logic [BLOCK_W-1:0] dma_tx_data = '0, dma_rx_data;
    logic               dma_done, dma_idle, dma_error;
    logic               mem_req, mem_we, mem_ready = 0;
    logic [31:0]        mem_addr;
    logic [BUS_W-1:0]   mem_wdata, mem_rdata;

    dma_block_engine #(.BLOCK_W(BLOCK_W), .BUS_W(BUS_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .dma_rx_start(dma_rx_start), .dma_tx_start(dma_tx_start),
        .dma_rx_address(dma_rx_address), .dma_tx_address(dma_tx_address),
        .dma_tx_data(dma_tx_data), .dma_rx_data(dma_rx_data),
        .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr[13:2]];

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int done_cnt = 0, beats = 0, we_cnt = 0, stall_cnt = 0, mode = 0, ph = 0;
    bit allow_drop = 0;
    logic [31:0] aq [$];
    logic        p_stall = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) p_stall = 0;
        else begin
            if (p_stall && !allow_drop) begin
                checks++;
                if (!(mem_req === 1'b1 && mem_addr === p_addr && mem_we === p_we && mem_wdata === p_wdata)) begin
                    failures++;
                    $display("FAIL beat_hold: req=%0b addr=%h we=%0b wdata=%h required req=1 addr=%h we=%0b wdata=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
                end
            end
            if ((dma_rx_start || dma_tx_start) && dma_idle) start_cyc = cyc;
            if (dma_done) begin done_cnt++; done_cyc = cyc; end
            if (mem_req && !mem_ready) stall_cnt++;
            if (mem_req && mem_ready) begin
                beats++;
                aq.push_back(mem_addr);
                if (mem_we) begin we_cnt++; mem[mem_addr[13:2]] = mem_wdata; end
            end
            p_stall = mem_req && !mem_ready;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
        end
    end

    always @(posedge clk) begin
        #2;
        case (mode)
            0: mem_ready = 1'b1;
            1: begin ph = (ph + 1) % 3; mem_ready = ph == 0; end
            2: mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = beats != 5;
        endcase
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic clear();
        beats = 0; done_cnt = 0; we_cnt = 0; stall_cnt = 0; aq.delete();
    endtask

    task automatic pulse_rx(input logic [31:0] a);
        step();
        dma_rx_address = a; dma_rx_start = 1;
        step();
        dma_rx_start = 0;
    endtask

    task automatic pulse_tx(input logic [31:0] a, input logic [BLOCK_W-1:0] d);
        step();
        dma_tx_address = a; dma_tx_data = d; dma_tx_start = 1;
        step();
        dma_tx_start = 0;
        dma_tx_data = {32{$urandom}};
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin step(); n++; end
        checks++;
        if (done_cnt == 0) begin failures++; $display("FAIL done_timeout: no dma_done within %0d cycles", bound); end
        repeat (3) step();
    endtask

    function automatic int addr_errs(input logic [31:0] base, input int n);
        int bad = (aq.size() != n) ? 1 : 0;
        for (int k = 0; k < aq.size() && k < n; k++) if (aq[k] !== base + 32'(4 * k)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({dma_done, dma_idle, dma_error, mem_req, mem_we} !== 5'b01000 || mem_addr !== 0 || mem_wdata !== 0 || dma_rx_data !== '0) begin
            failures++;
            $display("FAIL reset_values: done=%0b idle=%0b err=%0b req=%0b we=%0b addr=%h required 0,1,0,0,0,0", dma_done, dma_idle, dma_error, mem_req, mem_we, mem_addr);
        end
        reset = 0;
        mode = 0;
        for (int k = 0; k < BEATS; k++) mem[12'h400 + k] = $urandom | 1;
        clear();
        pulse_rx(32'h1000);
        repeat (4) step();
        @(posedge clk); #3;
        reset = 1;
        #1;
        checks++;
        if (dma_idle !== 1'b1 || mem_req !== 1'b0 || dma_done !== 1'b0 || dma_error !== 1'b0 || dma_rx_data !== '0) begin
            failures++;
            $display("FAIL async_reset: idle=%0b req=%0b done=%0b err=%0b rx_zero=%0b required idle=1 req=0 done=0 err=0 rx_zero=1", dma_idle, mem_req, dma_done, dma_error, dma_rx_data == '0);
        end
        step();
        reset = 0;
    endtask

    task automatic test_aligned_read();
        logic [BLOCK_W-1:0] exp;
        mode = 0;
        for (int k = 0; k < BEATS; k++) begin mem[12'h400 + k] = k + 1; exp[k*BUS_W +: BUS_W] = k + 1; end
        clear();
        pulse_rx(32'h1000);
        wait_done(200);
        checks++;
        if (addr_errs(32'h1000, BEATS) != 0) begin failures++; $display("FAIL read_addrs: beats=%0d bad=%0d required 32 beats at 0x1000+4k", aq.size(), addr_errs(32'h1000, BEATS)); end
        checks++;
        if (done_cyc - start_cyc != BEATS + 1) begin failures++; $display("FAIL read_latency: got %0d required %0d", done_cyc - start_cyc, BEATS + 1); end
        checks++;
        if (done_cnt != 1 || dma_error !== 1'b0 || we_cnt != 0) begin failures++; $display("FAIL read_status: done=%0d err=%0b writes=%0d required 1,0,0", done_cnt, dma_error, we_cnt); end
        checks++;
        if (dma_rx_data[31:0] !== 32'd1 || dma_rx_data[1023:992] !== 32'd32) begin failures++; $display("FAIL read_ends: low=%h high=%h required 1 and 32", dma_rx_data[31:0], dma_rx_data[1023:992]); end
        checks++;
        if (dma_rx_data !== exp || dma_idle !== 1'b1) begin failures++; $display("FAIL read_block: data_ok=%0b idle=%0b required 1,1", dma_rx_data === exp, dma_idle); end
    endtask

    task automatic test_write_stall();
        logic [BLOCK_W-1:0] blk;
        int bad = 0;
        for (int k = 0; k < BEATS; k++) blk[k*BUS_W +: BUS_W] = 32'hA5A50000 + k;
        mode = 1;
        clear();
        pulse_tx(32'h2000, blk);
        wait_done(400);
        for (int k = 0; k < BEATS; k++) if (mem[12'h800 + k] !== 32'hA5A50000 + k) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL write_mem: %0d words wrong, required 0", bad); end
        checks++;
        if (beats != BEATS || we_cnt != BEATS || addr_errs(32'h2000, BEATS) != 0) begin failures++; $display("FAIL write_beats: beats=%0d writes=%0d required 32,32 in order", beats, we_cnt); end
        checks++;
        if (done_cnt != 1 || dma_error !== 1'b0 || stall_cnt == 0) begin failures++; $display("FAIL write_status: done=%0d err=%0b stalls=%0d required 1,0,>0", done_cnt, dma_error, stall_cnt); end
        mode = 0;
    endtask

    task automatic test_errors();
        mode = 0;
        clear();
        pulse_rx(32'h1002);
        wait_done(20);
        checks++;
        if (beats != 0 || stall_cnt != 0 || dma_error !== 1'b1 || done_cnt != 1 || dma_idle !== 1'b1) begin
            failures++;
            $display("FAIL misaligned: beats=%0d stalls=%0d err=%0b done=%0d idle=%0b required 0,0,1,1,1", beats, stall_cnt, dma_error, done_cnt, dma_idle);
        end
        clear();
        step();
        dma_rx_address = 32'h1000; dma_tx_address = 32'h2000;
        dma_rx_start = 1; dma_tx_start = 1;
        step();
        dma_rx_start = 0; dma_tx_start = 0;
        wait_done(20);
        checks++;
        if (beats != 0 || stall_cnt != 0 || dma_error !== 1'b1 || done_cnt != 1 || dma_idle !== 1'b1) begin
            failures++;
            $display("FAIL both_starts: beats=%0d stalls=%0d err=%0b done=%0d idle=%0b required 0,0,1,1,1", beats, stall_cnt, dma_error, done_cnt, dma_idle);
        end
        clear();
        pulse_rx(32'h1000);
        wait_done(200);
        checks++;
        if (dma_error !== 1'b0 || done_cnt != 1 || beats != BEATS) begin failures++; $display("FAIL error_clear: err=%0b done=%0d beats=%0d required 0,1,32", dma_error, done_cnt, beats); end
    endtask

    task automatic test_busy_start();
        int n = 0;
        mode = 0;
        clear();
        pulse_rx(32'h1000);
        repeat (5) step();
        dma_tx_address = 32'h2000; dma_tx_start = 1;
        step();
        dma_tx_start = 0;
        wait_done(200);
        checks++;
        if (beats != BEATS || we_cnt != 0 || done_cnt != 1 || dma_error !== 1'b0) begin
            failures++;
            $display("FAIL busy_start: beats=%0d writes=%0d done=%0d err=%0b required 32,0,1,0", beats, we_cnt, done_cnt, dma_error);
        end
        clear();
        pulse_rx(32'h1000);
        while (beats < 10 && n < 100) begin step(); n++; end
        #1;
        reset = 1;
        #1;
        checks++;
        if (dma_idle !== 1'b1 || mem_req !== 1'b0 || beats != 10) begin failures++; $display("FAIL beat10_reset: idle=%0b req=%0b beats=%0d required 1,0,10", dma_idle, mem_req, beats); end
        step();
        reset = 0;
        repeat (5) step();
        checks++;
        if (done_cnt != 0 || dma_idle !== 1'b1) begin failures++; $display("FAIL abort_no_done: done=%0d idle=%0b required 0,1", done_cnt, dma_idle); end
    endtask

    task automatic test_random();
        logic [BLOCK_W-1:0] blk;
        logic [31:0]        base;
        int                 bad;
        bit                 rd;
        mode = 2;
        for (int it = 0; it < 8; it++) begin
            base = 32'($urandom_range(0, 4095 - BEATS)) << 2;
            rd   = 1'($urandom_range(0, 1));
            for (int k = 0; k < BEATS; k++) blk[k*BUS_W +: BUS_W] = $urandom;
            if (rd) for (int k = 0; k < BEATS; k++) mem[base[13:2] + 12'(k)] = blk[k*BUS_W +: BUS_W];
            clear();
            if (rd) pulse_rx(base); else pulse_tx(base, blk);
            wait_done(2000);
            bad = 0;
            if (rd) bad = (dma_rx_data !== blk) ? 1 : 0;
            else for (int k = 0; k < BEATS; k++) if (mem[base[13:2] + 12'(k)] !== blk[k*BUS_W +: BUS_W]) bad++;
            checks++;
            if (bad != 0 || beats != BEATS || we_cnt != (rd ? 0 : BEATS) || addr_errs(base, BEATS) != 0 || done_cnt != 1 || dma_error !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d: rd=%0b base=%h data_bad=%0d beats=%0d writes=%0d done=%0d err=%0b required 0 bad, 32 beats, 1 done, err 0",
                         it, rd, base, bad, beats, we_cnt, done_cnt, dma_error);
            end
        end
        mode = 0;
    endtask

`ifdef DMA_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        for (int k = 0; k < BEATS; k++) mem[12'h400 + k] = $urandom;
        mode = 3;
        allow_drop = 1;
        clear();
        pulse_rx(32'h1000);
        wait_done(200);
        for (int k = 0; k < 5; k++) if (dma_rx_data[k*BUS_W +: BUS_W] !== mem[12'h400 + k]) bad++;
        checks++;
        if (stall_cnt != 16 || mem_req !== 1'b0) begin failures++; $display("FAIL timeout_drop: stalls=%0d req=%0b required 16,0", stall_cnt, mem_req); end
        checks++;
        if (dma_error !== 1'b1 || done_cnt != 1 || beats != 5 || bad != 0) begin
            failures++;
            $display("FAIL timeout_status: err=%0b done=%0d beats=%0d bad_words=%0d required 1,1,5,0", dma_error, done_cnt, beats, bad);
        end
        mode = 0;
        allow_drop = 0;
        repeat (2) step();
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_read();
        test_write_stall();
        test_errors();
        test_busy_start();
        test_random();
`ifdef DMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_block_engine.md
Name: dma_block_engine

Overview:
- Responder end of the accelerator DMA handshake. Services the one-cycle `dma_rx_start` / `dma_tx_start` requests raised by the compute top level.
- Each request moves one BLOCK_W-bit operand block between system memory and the accelerator through a narrow word-wide memory port.
- Reports completion and status with `dma_done`, `dma_idle` and `dma_error`.
- Sits between the accelerator top level and the memory interconnect.

Parameters:
- BLOCK_W, 1024, width of one DMA block (operand width).
- BUS_W, 32, memory data-bus width. BLOCK_W must be a multiple of BUS_W.
- TIMEOUT_CYCLES, 256, per-beat wait limit. Used only when DMA_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dma_rx_start  in  1  one-cycle pulse: read a block from memory at dma_rx_address.
- dma_tx_start  in  1  one-cycle pulse: write dma_tx_data to memory at dma_tx_address.
- dma_rx_address  in  32  byte address of the block to read.
- dma_tx_address  in  32  byte address of the block to write.
- dma_tx_data  in  BLOCK_W  block to write. Sampled on the dma_tx_start cycle.
- dma_rx_data  out  BLOCK_W  assembled read block.
- dma_done  out  1  one-cycle pulse at the end of a transfer.
- dma_idle  out  1  high when the engine can accept a start.
- dma_error  out  1  sticky error flag. Cleared by the next accepted start.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  beat byte address.
- mem_wdata  out  BUS_W  write beat data.
- mem_rdata  in  BUS_W  read beat data. Valid when mem_ready is high.
- mem_ready  in  1  beat accepted/completed this cycle.

Behaviour:
- Reset values: all outputs 0, except dma_idle = 1. The state machine returns to IDLE, the beat counter is cleared and dma_rx_data is cleared. A reset asserted mid-transfer aborts the transfer with no done pulse; memory beats already issued are not retried.
- BEATS = BLOCK_W/BUS_W (32 at defaults). Beat k uses address base + k*(BUS_W/8) and maps to block bits [k*BUS_W +: BUS_W], so beat 0 is the least-significant word.
- State machine states: IDLE, RD, WR, DONE.
- IDLE:
  - dma_idle = 1.
  - On dma_rx_start: latch dma_rx_address, clear dma_error, go to RD.
  - On dma_tx_start: latch the address and the full dma_tx_data, clear dma_error, go to WR.
  - If both starts are high in the same cycle: no transfer, set dma_error, pulse dma_done, stay in IDLE.
  - If the latched base address has bits [1:0] != 0: set dma_error, go to DONE, issue no beats.
- RD / WR:
  - mem_req is held high with mem_addr and mem_we (plus mem_wdata in WR) stable until a cycle with mem_ready = 1.
  - That cycle completes the beat. In RD the engine captures mem_rdata into the beat slot, then advances the counter.
  - After beat BEATS-1 completes, go to DONE. mem_req drops in the cycle after the last ready.
  - There is no back-to-back bubble requirement: the next beat's request is asserted in the cycle after the previous ready.
- DONE: dma_done = 1 for exactly one cycle, then IDLE. dma_idle is 0 in RD, WR and DONE.
- Minimum latency from the start pulse to dma_done, with mem_ready tied high: BEATS+1 cycles.
- Starts arriving while not in IDLE are ignored, with no error.
- dma_rx_data holds its value from the dma_done cycle until the next RD transfer begins. It updates word by word during RD.
- dma_tx_data may change after its start cycle without affecting the transfer in progress.

Optional Feature:
- DMA_TIMEOUT_EN defined:
  - A per-beat counter runs while mem_req is high and mem_ready is low.
  - On reaching TIMEOUT_CYCLES: drop mem_req, set dma_error, go to DONE (the done pulse is still issued).
  - A partially read block remains in dma_rx_data.
- DMA_TIMEOUT_EN undefined: the engine waits indefinitely for mem_ready, and no counter logic is instantiated.

Test Plan:
- Reset values: assert reset asynchronously mid-cycle -> all outputs 0, dma_idle = 1, immediately without waiting for a clock edge.
- Aligned read: memory word at 0x1000 + 4k = k+1, mem_ready tied high, dma_rx_start pulse with address 0x1000 -> 32 read beats at 0x1000..0x107C, dma_rx_data[31:0] = 1 and [1023:992] = 32, dma_done one pulse 33 cycles after start, dma_error = 0.
- Write with stalls: dma_tx_data = {32 words 0xA5A50000+k}, address 0x2000, mem_ready high every third cycle -> each beat's address and data held until ready, memory holds 0xA5A50000+k at 0x2000 + 4k, single done pulse.
- Error conditions:
  - Misaligned start (rx address 0x1002) -> no mem_req, dma_error = 1, one done pulse, then dma_idle = 1.
  - Both starts high in the same cycle -> dma_error = 1, one done pulse, no mem_req.
  - A following good rx -> dma_error clears.
- Start while busy: dma_tx_start pulse during a read -> ignored, no extra beats, exactly one done pulse. Reset at beat 10 -> dma_idle = 1 with no done pulse.
- DMA_TIMEOUT_EN with TIMEOUT_CYCLES = 16: mem_ready stuck low on beat 5 -> mem_req drops after 16 cycles, dma_error = 1, one done pulse, words 0..4 retained in dma_rx_data.
